// File: rtl/spmv_pkg.sv
// Shared AXI codes and FSM states for the SpMV vector RAM responder.
package spmv_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_256B   = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_START,
        RD_DATA
    } state_t;
endpackage

// File: rtl/spmv_bram_sp.sv
// Single-port 256-bit RAM with byte write enables and a registered, enabled read.
module spmv_bram_sp #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  re_i,
    input  logic [31:0]           we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [255:0]          wdata_i,
    output logic [255:0]          rdata_o
);
    logic [255:0] mem_q [1 << DEPTH_LOG2];
    logic [255:0] rdata_q;

    // Read output only moves on re_i, so it holds across responder stalls.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 32; b++) begin
            if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/spmv_vector_ram_responder.sv
// AXI responder backing the vector loader's HBM master with on-chip RAM,
// one transaction at a time.
module spmv_vector_ram_responder
    import spmv_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic         pcie_aclk,
    input  logic         pcie_areset,
    input  logic [32:0]  s_axi_hbm_awaddr,
    input  logic [3:0]   s_axi_hbm_awlen,
    input  logic [2:0]   s_axi_hbm_awsize,
    input  logic [1:0]   s_axi_hbm_awburst,
    input  logic         s_axi_hbm_awvalid,
    output logic         s_axi_hbm_awready,
    input  logic [255:0] s_axi_hbm_wdata,
    input  logic [31:0]  s_axi_hbm_wstrb,
    input  logic         s_axi_hbm_wlast,
    input  logic         s_axi_hbm_wvalid,
    output logic         s_axi_hbm_wready,
    output logic [1:0]   s_axi_hbm_bresp,
    output logic         s_axi_hbm_bvalid,
    input  logic         s_axi_hbm_bready,
    input  logic [32:0]  s_axi_hbm_araddr,
    input  logic [3:0]   s_axi_hbm_arlen,
    input  logic [2:0]   s_axi_hbm_arsize,
    input  logic [1:0]   s_axi_hbm_arburst,
    input  logic         s_axi_hbm_arvalid,
    output logic         s_axi_hbm_arready,
    output logic [255:0] s_axi_hbm_rdata,
    output logic [1:0]   s_axi_hbm_rresp,
    output logic         s_axi_hbm_rlast,
    output logic         s_axi_hbm_rvalid,
    input  logic         s_axi_hbm_rready
);
    localparam int IW = DEPTH_LOG2;

    state_t        state_q, state_d;
    logic [IW-1:0] addr_q, addr_d, addr_nxt, ram_addr;
    logic [4:0]    cnt_q, cnt_d, cnt_inc;
    logic [3:0]    len_q, len_d;
    logic [1:0]    burst_q, burst_d, resp_q, resp_d;
    logic          wr_prio_q, wr_prio_d;
    logic          wr_grant, rd_grant, last_beat, err, ram_re;
    logic [31:0]   ram_we;
    logic [255:0]  ram_rdata;

    // Whole-burst classification at address time; DECERR outranks SLVERR.
    function automatic logic [1:0] classify(input logic [32:0] addr, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
        logic [IW:0] end_idx;
        end_idx = {1'b0, addr[5 +: IW]} + ((burst == BURST_INCR) ? (IW+1)'(len) : '0);
        if ((addr >> (5 + IW)) != '0 || end_idx[IW]) return RESP_DECERR;
        if (size != SIZE_256B || (burst != BURST_INCR && burst != BURST_FIXED)) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    assign wr_grant  = (state_q == IDLE) && s_axi_hbm_awvalid && (wr_prio_q || !s_axi_hbm_arvalid);
    assign rd_grant  = (state_q == IDLE) && s_axi_hbm_arvalid && (!wr_prio_q || !s_axi_hbm_awvalid);
    assign err       = (resp_q != RESP_OKAY);
    assign last_beat = (cnt_q == {1'b0, len_q});
    assign addr_nxt  = addr_q + IW'(burst_q == BURST_INCR);
    assign cnt_inc   = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;

    always_ff @(posedge pcie_aclk) begin
        if (pcie_areset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            burst_q   <= BURST_FIXED;
            resp_q    <= RESP_OKAY;
            wr_prio_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            resp_q    <= resp_d;
            wr_prio_q <= wr_prio_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        burst_d   = burst_q;
        resp_d    = resp_q;
        wr_prio_d = wr_prio_q;
        ram_we    = '0;
        ram_re    = 1'b0;
        ram_addr  = addr_q;
        case (state_q)
            IDLE: begin
                if (wr_grant) begin
                    state_d   = WR_DATA;
                    addr_d    = s_axi_hbm_awaddr[5 +: IW];
                    len_d     = s_axi_hbm_awlen;
                    burst_d   = s_axi_hbm_awburst;
                    resp_d    = classify(s_axi_hbm_awaddr, s_axi_hbm_awlen, s_axi_hbm_awsize, s_axi_hbm_awburst);
                    cnt_d     = '0;
                    wr_prio_d = 1'b0;
                end else if (rd_grant) begin
                    state_d   = RD_START;
                    addr_d    = s_axi_hbm_araddr[5 +: IW];
                    len_d     = s_axi_hbm_arlen;
                    burst_d   = s_axi_hbm_arburst;
                    resp_d    = classify(s_axi_hbm_araddr, s_axi_hbm_arlen, s_axi_hbm_arsize, s_axi_hbm_arburst);
                    cnt_d     = '0;
                    wr_prio_d = 1'b1;
                end
            end
            WR_DATA: begin
                if (s_axi_hbm_wvalid) begin
                    // Beats past awlen+1 are dropped so a runaway burst never wraps the RAM.
                    if (!err && cnt_q <= {1'b0, len_q}) ram_we = s_axi_hbm_wstrb;
                    cnt_d  = cnt_inc;
                    addr_d = addr_nxt;
                    if (s_axi_hbm_wlast) begin
                        state_d = WR_RESP;
                        if (!last_beat && !err) resp_d = RESP_SLVERR;
                    end
                end
            end
            WR_RESP: begin
                if (s_axi_hbm_bready) state_d = IDLE;
            end
            RD_START: begin
                ram_re  = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (s_axi_hbm_rready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d    = cnt_inc;
                        addr_d   = addr_nxt;
                        ram_re   = 1'b1;
                        ram_addr = addr_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pcie_areset) begin
            ram_we = '0;
            ram_re = 1'b0;
        end
    end

    always_comb begin
        s_axi_hbm_awready = !pcie_areset && wr_grant;
        s_axi_hbm_arready = !pcie_areset && rd_grant;
        s_axi_hbm_wready  = !pcie_areset && (state_q == WR_DATA);
        s_axi_hbm_bvalid  = !pcie_areset && (state_q == WR_RESP);
        s_axi_hbm_bresp   = s_axi_hbm_bvalid ? resp_q : RESP_OKAY;
        s_axi_hbm_rvalid  = !pcie_areset && (state_q == RD_DATA);
        s_axi_hbm_rresp   = s_axi_hbm_rvalid ? resp_q : RESP_OKAY;
        s_axi_hbm_rlast   = s_axi_hbm_rvalid && last_beat;
        s_axi_hbm_rdata   = (s_axi_hbm_rvalid && !err) ? ram_rdata : '0;
    end

    spmv_bram_sp #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bram (
        .clk_i  (pcie_aclk),
        .re_i   (ram_re),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wdata_i(s_axi_hbm_wdata),
        .rdata_o(ram_rdata)
    );
endmodule

// File: tb/tb_spmv_vector_ram_responder.sv
// Randomized bench for the vector RAM responder against a word-array reference model.
module tb_spmv_vector_ram_responder;
    localparam int DL = 10;
    localparam int NW = 1 << DL;

    logic         clk = 1'b0;
    logic         rst;
    logic [32:0]  awaddr, araddr;
    logic [3:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [255:0] wdata, rdata;
    logic [31:0]  wstrb;

    logic [255:0] mdl [NW];
    bit           known [NW];
    int           total = 0;
    int           bad = 0;
    bit           gq [$];

    always #5 clk = ~clk;

    spmv_vector_ram_responder #(.DEPTH_LOG2(DL)) dut (
        .pcie_aclk(clk), .pcie_areset(rst),
        .s_axi_hbm_awaddr(awaddr), .s_axi_hbm_awlen(awlen), .s_axi_hbm_awsize(awsize),
        .s_axi_hbm_awburst(awburst), .s_axi_hbm_awvalid(awvalid), .s_axi_hbm_awready(awready),
        .s_axi_hbm_wdata(wdata), .s_axi_hbm_wstrb(wstrb), .s_axi_hbm_wlast(wlast),
        .s_axi_hbm_wvalid(wvalid), .s_axi_hbm_wready(wready),
        .s_axi_hbm_bresp(bresp), .s_axi_hbm_bvalid(bvalid), .s_axi_hbm_bready(bready),
        .s_axi_hbm_araddr(araddr), .s_axi_hbm_arlen(arlen), .s_axi_hbm_arsize(arsize),
        .s_axi_hbm_arburst(arburst), .s_axi_hbm_arvalid(arvalid), .s_axi_hbm_arready(arready),
        .s_axi_hbm_rdata(rdata), .s_axi_hbm_rresp(rresp), .s_axi_hbm_rlast(rlast),
        .s_axi_hbm_rvalid(rvalid), .s_axi_hbm_rready(rready)
    );

    // Grant order log: 1 = write accepted, 0 = read accepted.
    always @(negedge clk) begin
        if (awvalid && awready) gq.push_back(1'b1);
        if (arvalid && arready) gq.push_back(1'b0);
    end

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [32:0] a, input int len,
                                            input logic [2:0] sz, input logic [1:0] bu);
        longint hi;
        int idx;
        hi  = longint'(a) / (longint'(1) << (5 + DL));
        idx = int'((a >> 5) % NW);
        if (hi != 0) return 2'b11;
        if (bu == 2'd1 && idx + len >= NW) return 2'b11;
        if (sz != 3'd5 || bu > 2'd1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic wr(input logic [32:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu,
                      input int nbeats, input logic [31:0] strb, input bit rs);
        logic [1:0]   er, eb;
        logic [255:0] d;
        logic [31:0]  st;
        int idx, w, n;
        er  = exp_resp(a, len, sz, bu);
        idx = int'((a >> 5) % NW);
        @(posedge clk) #1;
        awaddr = a; awlen = 4'(len); awsize = sz; awburst = bu; awvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (awready) break;
            if (++n > 200) begin chk("aw_timeout", 0, 1); awvalid = 1'b0; return; end
        end
        @(posedge clk) #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            st = rs ? $urandom : strb;
            wdata = d; wstrb = st; wlast = (i == nbeats - 1); wvalid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (wready) break;
                if (++n > 200) begin chk("w_timeout", 0, 1); wvalid = 1'b0; return; end
            end
            if (er == 2'b00) begin
                w = (idx + (bu == 2'd1 ? i : 0)) % NW;
                if (nbeats == len + 1) begin
                    for (int b = 0; b < 32; b++) if (st[b]) mdl[w][b*8 +: 8] = d[b*8 +: 8];
                    known[w] = known[w] || (st == 32'hffff_ffff);
                end else if (i <= len) begin
                    known[w] = 1'b0;
                end
            end
            @(posedge clk) #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        eb = (er != 2'b00) ? er : ((nbeats != len + 1) ? 2'b10 : 2'b00);
        n = 0;
        forever begin
            @(negedge clk);
            if (bvalid) break;
            if (++n > 200) begin chk("b_timeout", 0, 1); return; end
        end
        chk("bresp", bresp, eb);
        bready = 1'b1;
        @(posedge clk) #1;
        bready = 1'b0;
    endtask

    task automatic rd(input logic [32:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu,
                      input bit bp, input int abort_after);
        logic [1:0]   er;
        logic [255:0] held, ed;
        logic [3:0]   pat;
        bit stalled;
        int idx, w, n, got, t, ph;
        er  = exp_resp(a, len, sz, bu);
        idx = int'((a >> 5) % NW);
        pat = 4'b1001;
        @(posedge clk) #1;
        araddr = a; arlen = 4'(len); arsize = sz; arburst = bu; arvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (arready) break;
            if (++n > 200) begin chk("ar_timeout", 0, 1); arvalid = 1'b0; return; end
        end
        @(posedge clk) #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);
        chk("rvalid_lat1", rvalid, 0);
        got = 0; t = 0; ph = 0; stalled = 1'b0; held = '0;
        while (got <= len) begin
            @(posedge clk) #1;
            rready = bp ? pat[ph % 4] : 1'b1;
            ph++;
            @(negedge clk);
            if (t == 0) chk("rvalid_lat2", rvalid, 1);
            if (++t > 200) begin chk("r_timeout", 0, 1); break; end
            if (!rvalid) continue;
            if (stalled) chk("r_hold", rdata, held);
            if (!rready) begin stalled = 1'b1; held = rdata; continue; end
            stalled = 1'b0;
            w  = (idx + (bu == 2'd1 ? got : 0)) % NW;
            ed = (er != 2'b00) ? '0 : mdl[w];
            if (er != 2'b00 || known[w]) chk("rdata", rdata, ed);
            chk("rresp", rresp, er);
            chk("rlast", rlast, got == len);
            got++;
            if (abort_after != 0 && got == abort_after) begin
                @(posedge clk) #1;
                rst = 1'b1; rready = 1'b0;
                @(negedge clk);
                chk("rvalid_in_rst", rvalid, 0);
                @(posedge clk) #1;
                rst = 1'b0;
                @(negedge clk);
                chk("rvalid_after_rst", rvalid, 0);
                return;
            end
        end
        @(posedge clk) #1;
        rready = 1'b0;
        @(negedge clk);
        chk("rvalid_end", rvalid, 0);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awlen = '0; awsize = 3'd5; awburst = 2'd1; awvalid = 1'b1;
        araddr = '0; arlen = '0; arsize = 3'd5; arburst = 2'd1; arvalid = 1'b1;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b1; bready = 1'b0; rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rlast", rlast, 0);
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0; rready = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        gq.delete();

        // Two simultaneous AW/AR pairs: 4-beat write/read at 0x40, then 8 beats at 0x100.
        fork
            wr(33'h40, 3, 3'd5, 2'd1, 4, 32'hffff_ffff, 1'b0);
            rd(33'h40, 3, 3'd5, 2'd1, 1'b0, 0);
        join
        fork
            wr(33'h100, 7, 3'd5, 2'd1, 8, 32'hffff_ffff, 1'b0);
            rd(33'h100, 7, 3'd5, 2'd1, 1'b1, 0);
        join
        chk("grant_order", {28'(gq.size()), (gq.size() == 4) ? {gq[0], gq[1], gq[2], gq[3]} : 4'h0},
            {28'd4, 4'b1010});

        for (int k = 0; k < 3; k++) wr(33'(k * 16) << 5, 15, 3'd5, 2'd1, 16, 32'hffff_ffff, 1'b0);

        rd(33'h100, 7, 3'd5, 2'd1, 1'b1, 0);

        wr(33'hA0, 0, 3'd5, 2'd1, 1, 32'h0000_000f, 1'b0);
        rd(33'hA0, 0, 3'd5, 2'd1, 1'b0, 0);

        wr(33'h1_0000_0000, 0, 3'd5, 2'd1, 1, 32'hffff_ffff, 1'b0);
        rd(33'h0, 0, 3'd5, 2'd1, 1'b0, 0);

        rd(33'h40, 3, 3'b100, 2'd1, 1'b0, 0);
        wr(33'h200, 3, 3'd5, 2'd1, 2, 32'hffff_ffff, 1'b0);
        wr(33'((NW - 2) * 32), 3, 3'd5, 2'd1, 4, 32'hffff_ffff, 1'b0);
        rd(33'h60, 2, 3'd5, 2'd0, 1'b0, 0);

        rd(33'h100, 7, 3'd5, 2'd1, 1'b0, 2);
        rd(33'h100, 7, 3'd5, 2'd1, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [32:0] a;
            logic [2:0]  sz;
            logic [1:0]  bu;
            int          len, w;
            w = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) w = NW - 1 - $urandom_range(0, 3);
            a = 33'(w) << 5;
            if ($urandom_range(0, 9) == 0) a[32] = 1'b1;
            len = $urandom_range(0, 7);
            sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd5;
            bu  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                wr(a, len, sz, bu, (len > 0 && $urandom_range(0, 7) == 0) ? len : len + 1, 32'hffff_ffff, 1'b1);
            else
                rd(a, len, sz, bu, 1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
